// File: rtl/out_bcd_display.sv
// Display back-end for the CPU out port: converts each new 16-bit value to five
// BCD digits with a serial double-dabble engine and scans them onto a 7-segment display.
module out_bcd_display #(
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    output logic [19:0] bcd,
    output logic        busy,
    output logic        done,
    output logic [4:0]  digit_en,
    output logic [6:0]  seg
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t             state_r;
    logic [15:0]        last_r;
    logic [35:0]        shift_r;
    logic [3:0]         iter_r;
    logic [DIV_W-1:0]   div_r;

    logic [35:0]        step_s;
    logic [4:0]         next_en_s;
    logic [3:0]         nib_s;
    logic [6:0]         seg_next_s;
    logic               div_wrap_s;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [35:0] dabble_step(input logic [35:0] sr);
        logic [35:0] adj;
        adj = sr;
        for (int k = 0; k < 5; k++) begin
            if (adj[16 + 4*k +: 4] >= 4'd5) begin
                adj[16 + 4*k +: 4] = adj[16 + 4*k +: 4] + 4'd3;
            end else begin
                adj[16 + 4*k +: 4] = adj[16 + 4*k +: 4];
            end
        end
        return {adj[34:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] nibble_sel(input logic [19:0] b, input logic [4:0] onehot);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 5; k++) begin
            if (onehot[k]) begin
                n = b[4*k +: 4];
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // True when the selected digit (never digit 0) and all digits above it are zero.
    function automatic logic upper_zero(input logic [19:0] b, input logic [4:0] onehot);
        logic z;
        z = 1'b0;
        for (int k = 1; k < 5; k++) begin
            if (onehot[k] && ((b >> (4*k)) == 20'd0)) begin
                z = 1'b1;
            end else begin
                z = z;
            end
        end
        return z;
    endfunction

    // Next shift-register value, next digit select and its segment pattern.
    always_comb begin
        step_s     = dabble_step(shift_r);
        next_en_s  = {digit_en[3:0], digit_en[4]};
        nib_s      = nibble_sel(bcd, next_en_s);
        div_wrap_s = (div_r == DIV_W'(SCAN_DIV - 1));
        if ((BLANK_LZ != 0) && upper_zero(bcd, next_en_s)) begin
            seg_next_s = 7'b1111111;
        end else begin
            seg_next_s = seg_decode(nib_s);
        end
    end

    // Conversion FSM: samples value on change, then runs 16 dabble iterations.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            last_r  <= 16'd0;
            shift_r <= 36'd0;
            iter_r  <= 4'd0;
            bcd     <= 20'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (value != last_r) begin
                        last_r  <= value;
                        shift_r <= {20'd0, value};
                        iter_r  <= 4'd0;
                        busy    <= 1'b1;
                        state_r <= ST_CONV;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    shift_r <= step_s;
                    iter_r  <= iter_r + 4'd1;
                    if (iter_r == 4'd15) begin
                        bcd     <= step_s[35:16];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_CONV;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running scan: seg and digit_en move together on each divider wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r    <= '0;
            digit_en <= 5'b00001;
            seg      <= 7'b1000000;
        end else if (div_wrap_s) begin
            div_r    <= '0;
            digit_en <= next_en_s;
            seg      <= seg_next_s;
        end else begin
            div_r    <= div_r + DIV_W'(1);
        end
    end

endmodule

// File: tb/tb_out_bcd_display.sv
// Self-checking bench for out_bcd_display: an arithmetic reference model compared every
// cycle against three instances (blanking on/off, slow and fast scan), plus literal checks.
module tb_out_bcd_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;

    logic [19:0] bcd_a, bcd_b, bcd_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [4:0]  en_a, en_b, en_c;
    logic [6:0]  seg_a, seg_b, seg_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    out_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1)) dut_a (
        .clk(clk), .rst(rst), .value(value), .bcd(bcd_a), .busy(busy_a),
        .done(done_a), .digit_en(en_a), .seg(seg_a));
    out_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(0)) dut_b (
        .clk(clk), .rst(rst), .value(value), .bcd(bcd_b), .busy(busy_b),
        .done(done_b), .digit_en(en_b), .seg(seg_b));
    out_bcd_display #(.SCAN_DIV(1), .BLANK_LZ(1)) dut_c (
        .clk(clk), .rst(rst), .value(value), .bcd(bcd_c), .busy(busy_c),
        .done(done_c), .digit_en(en_c), .seg(seg_c));

    // Reference model state: plain integers, decimal value of the displayed result.
    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    int sd_t [3] = '{4, 4, 1};
    int bl_t [3] = '{1, 0, 1};
    int m_valid = 0;
    int m_busy, m_iter, m_done, m_last, m_conv, m_val;
    int m_cnt [3];
    int m_dig [3];
    logic [6:0] m_seg [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int p;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int v, input int k, input int bl);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (bl != 0 && k >= 1 && v < p) return 7'b1111111;
        return seg_tbl[(v / p) % 10];
    endfunction

    task automatic model_step();
        if (rst) begin
            m_valid = 1; m_busy = 0; m_done = 0; m_last = 0; m_val = 0; m_iter = 0;
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0; m_dig[i] = 0; m_seg[i] = seg_tbl[0];
            end
        end else if (m_valid != 0) begin
            for (int i = 0; i < 3; i++) begin
                if (m_cnt[i] == sd_t[i] - 1) begin
                    m_cnt[i] = 0;
                    m_dig[i] = (m_dig[i] + 1) % 5;
                    m_seg[i] = seg_of(m_val, m_dig[i], bl_t[i]);
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            m_done = 0;
            if (m_busy == 0) begin
                if (int'(value) != m_last) begin
                    m_last = int'(value); m_conv = int'(value); m_busy = 1; m_iter = 0;
                end
            end else begin
                m_iter = m_iter + 1;
                if (m_iter == 16) begin
                    m_val = m_conv; m_done = 1; m_busy = 0;
                end
            end
        end
    endtask

    task automatic check_inst(input string t, input int i, input logic [19:0] b, input logic bz,
                              input logic dn, input logic [4:0] en, input logic [6:0] sg);
        chk({t, ".bcd"}, 32'(b), 32'(to_bcd(m_val)));
        chk({t, ".busy"}, 32'(bz), 32'(m_busy));
        chk({t, ".done"}, 32'(dn), 32'(m_done));
        chk({t, ".digit_en"}, 32'(en), 32'(1 << m_dig[i]));
        chk({t, ".seg"}, 32'(sg), 32'(m_seg[i]));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison of all three instances against the model.
    initial forever begin
        @(negedge clk);
        if (m_valid != 0) begin
            check_inst("a", 0, bcd_a, busy_a, done_a, en_a, seg_a);
            check_inst("b", 1, bcd_b, busy_b, done_b, en_b, seg_b);
            check_inst("c", 2, bcd_c, busy_c, done_c, en_c, seg_c);
        end
    end

    task automatic convert(input logic [15:0] v, input logic [19:0] exp);
        int nb;
        int got;
        nb = 0; got = 0;
        value = v;
        for (int i = 0; i < 40 && got == 0; i++) begin
            @(negedge clk);
            if (busy_a) nb++;
            if (done_a) got = 1;
        end
        chk("conv_busy_len", 32'(nb), 32'd16);
        chk("conv_done_seen", 32'(got), 32'd1);
        chk("conv_bcd", 32'(bcd_a), 32'(exp));
        @(negedge clk);
        chk("conv_done_single", 32'(done_a), 32'd0);
    endtask

    task automatic wait_en(input logic [4:0] target, output int cycles);
        cycles = 0;
        while (en_a !== target && cycles < 30) begin
            @(negedge clk);
            cycles++;
        end
        chk("wait_digit_en", 32'(en_a), 32'(target));
    endtask

    initial begin
        int nd;
        int nb;
        int cyc;
        logic [19:0] cap [2];
        cap[0] = 20'd0; cap[1] = 20'd0;
        rst = 1'b1;
        value = 16'd0;
        repeat (2) @(negedge clk);
        chk("rst_bcd", 32'(bcd_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_en", 32'(en_a), 32'b00001);
        chk("rst_seg", 32'(seg_a), 32'b1000000);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_no_conv", 32'(busy_a), 32'd0);

        convert(16'd12345, 20'h12345);
        convert(16'd65535, 20'h65535);
        convert(16'd9, 20'h00009);

        // value changes to 7 at E5 of the conversion of 100
        value = 16'd100;
        repeat (5) @(negedge clk);
        value = 16'd7;
        nd = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_a) begin
                if (nd < 2) cap[nd] = bcd_a;
                nd++;
            end
        end
        chk("mid_done_count", 32'(nd), 32'd2);
        chk("mid_first", 32'(cap[0]), 32'h00100);
        chk("mid_second", 32'(cap[1]), 32'h00007);

        repeat (25) @(negedge clk);
        wait_en(5'b00001, cyc);
        chk("scan_d0_blank", 32'(seg_a), 32'b1111000);
        chk("scan_d0_noblank", 32'(seg_b), 32'b1111000);
        wait_en(5'b00010, cyc);
        chk("scan_d1_blank", 32'(seg_a), 32'b1111111);
        chk("scan_d1_noblank", 32'(seg_b), 32'b1000000);
        wait_en(5'b00100, cyc);
        chk("scan_period", 32'(cyc), 32'd4);
        wait_en(5'b10000, cyc);
        chk("scan_d4_blank", 32'(seg_a), 32'b1111111);
        chk("scan_d4_noblank", 32'(seg_b), 32'b1000000);
        wait_en(5'b00001, cyc);
        chk("scan_wrap", 32'(cyc), 32'd4);

        // reset lands on E8 of the conversion of 500
        value = 16'd500;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_bcd", 32'(bcd_a), 32'd0);
        chk("rstmid_busy", 32'(busy_a), 32'd0);
        chk("rstmid_done", 32'(done_a), 32'd0);
        rst = 1'b0;
        convert(16'd500, 20'h00500);

        nd = 0; nb = 0;
        repeat (100) begin
            @(negedge clk);
            if (done_a) nd++;
            if (busy_a) nb++;
        end
        chk("stable_done", 32'(nd), 32'd0);
        chk("stable_busy", 32'(nb), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
